// File: rtl/alu_entry_fsm.sv
// Operand-entry and execute controller for the lab ALU: each step pulse captures A, B, then the
// opcode together with a registered result and flags, then clears result_valid and wraps.
module alu_entry_fsm #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             rstsync,
  input  logic             i_rise,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_a_reg,
  output logic [WIDTH-1:0] o_b_reg,
  output logic [2:0]       o_op_reg,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_result_valid,
  output logic [1:0]       o_state,
  output logic [WIDTH-1:0] o_display
);

  typedef enum logic [1:0] {
    StA   = 2'b00,
    StB   = 2'b01,
    StOp  = 2'b10,
    StRes = 2'b11
  } state_t;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [2:0]       r_op, w_op_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic             r_carry, w_carry_next;
  logic             r_zero, w_zero_next;
  logic             r_overflow, w_overflow_next;
  logic             r_valid, w_valid_next;

  // ALU evaluation uses the live opcode on the switches, since op_reg loads on the same edge.
  logic [2:0]       w_alu_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_zero;
  logic             w_alu_overflow;

  always_comb begin
    w_alu_op       = i_sw[2:0];
    w_sum          = {1'b0, r_a} + {1'b0, r_b};
    w_diff         = {1'b0, r_a} - {1'b0, r_b};
    w_alu_res      = '0;
    w_alu_carry    = 1'b0;
    w_alu_overflow = 1'b0;
    unique case (w_alu_op)
      OpAdd: begin
        w_alu_res      = w_sum[WIDTH-1:0];
        w_alu_carry    = w_sum[WIDTH];
        w_alu_overflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpSub: begin
        // Top bit of the widened difference is the unsigned borrow.
        w_alu_res      = w_diff[WIDTH-1:0];
        w_alu_carry    = w_diff[WIDTH];
        w_alu_overflow = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpAnd: w_alu_res = r_a & r_b;
      OpOr:  w_alu_res = r_a | r_b;
      OpXor: w_alu_res = r_a ^ r_b;
      OpNot: w_alu_res = ~r_a;
      OpShl: begin
        w_alu_res   = {r_a[WIDTH-2:0], 1'b0};
        w_alu_carry = r_a[WIDTH-1];
      end
      OpShr: begin
        w_alu_res   = {1'b0, r_a[WIDTH-1:1]};
        w_alu_carry = r_a[0];
      end
      default: w_alu_res = '0;
    endcase
    w_alu_zero = (w_alu_res == '0);
  end

  always_comb begin
    w_state_next    = r_state;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_op_next       = r_op;
    w_result_next   = r_result;
    w_carry_next    = r_carry;
    w_zero_next     = r_zero;
    w_overflow_next = r_overflow;
    w_valid_next    = r_valid;
    if (i_rise) begin
      unique case (r_state)
        StA: begin
          w_a_next     = i_sw;
          w_state_next = StB;
        end
        StB: begin
          w_b_next     = i_sw;
          w_state_next = StOp;
        end
        StOp: begin
          w_op_next       = w_alu_op;
          w_result_next   = w_alu_res;
          w_carry_next    = w_alu_carry;
          w_zero_next     = w_alu_zero;
          w_overflow_next = w_alu_overflow;
          w_valid_next    = 1'b1;
          w_state_next    = StRes;
        end
        StRes: begin
          w_valid_next = 1'b0;
          w_state_next = StA;
        end
        default: w_state_next = StA;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstsync) begin
    if (!rstsync) begin
      r_state    <= StA;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_op       <= w_op_next;
      r_result   <= w_result_next;
      r_carry    <= w_carry_next;
      r_zero     <= w_zero_next;
      r_overflow <= w_overflow_next;
      r_valid    <= w_valid_next;
    end
  end

  always_comb begin
    o_display = i_sw;
    unique case (r_state)
      StA, StB: o_display = i_sw;
      StOp:     o_display = {{(WIDTH-3){1'b0}}, i_sw[2:0]};
      StRes:    o_display = r_result;
      default:  o_display = i_sw;
    endcase
  end

  assign o_state        = r_state;
  assign o_a_reg        = r_a;
  assign o_b_reg        = r_b;
  assign o_op_reg       = r_op;
  assign o_result       = r_result;
  assign o_carry        = r_carry;
  assign o_zero         = r_zero;
  assign o_overflow     = r_overflow;
  assign o_result_valid = r_valid;

endmodule

// File: tb/tb_alu_entry_fsm.sv
// Scoreboard bench for alu_entry_fsm: stimulus pushes expected ALU outcomes, a monitor pops them
// whenever result_valid rises; an integer-arithmetic reference model supplies all expectations.
module tb_alu_entry_fsm;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clock = 1'b0;
  logic         rstsync = 1'b0;
  logic         i_rise = 1'b0;
  logic [W-1:0] i_sw = '0;
  logic [W-1:0] o_a_reg, o_b_reg, o_result, o_display;
  logic [2:0]   o_op_reg;
  logic         o_carry, o_zero, o_overflow, o_result_valid;
  logic [1:0]   o_state;

  alu_entry_fsm #(.WIDTH(W)) dut (
    .clock          (clock),
    .rstsync        (rstsync),
    .i_rise         (i_rise),
    .i_sw           (i_sw),
    .o_a_reg        (o_a_reg),
    .o_b_reg        (o_b_reg),
    .o_op_reg       (o_op_reg),
    .o_result       (o_result),
    .o_carry        (o_carry),
    .o_zero         (o_zero),
    .o_overflow     (o_overflow),
    .o_result_valid (o_result_valid),
    .o_state        (o_state),
    .o_display      (o_display)
  );

  always #5 clock = ~clock;

  typedef struct {
    int a; int b; int op; int res; int c; int z; int v;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;

  // Reference state: which step we are on and what has been captured so far.
  int m_state = 0, m_a = 0, m_b = 0, m_op = 0, m_valid = 0;
  int m_res = 0, m_c = 0, m_z = 0, m_v = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int res, output int c, output int z, output int v);
    int t;
    c = 0;
    v = 0;
    res = 0;
    case (op)
      0: begin
        t = a + b; res = t % M; c = (t >= M) ? 1 : 0;
        t = sgn(a) + sgn(b); v = (t < -M / 2 || t >= M / 2) ? 1 : 0;
      end
      1: begin
        t = a - b; res = (t + M) % M; c = (a < b) ? 1 : 0;
        t = sgn(a) - sgn(b); v = (t < -M / 2 || t >= M / 2) ? 1 : 0;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (M - 1) - a;
      6: begin res = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      7: begin res = a / 2; c = a % 2; end
      default: res = 0;
    endcase
    z = (res == 0) ? 1 : 0;
  endfunction

  function automatic int exp_display();
    if (m_state == 0 || m_state == 1) return int'(i_sw);
    if (m_state == 2) return int'(i_sw) % 8;
    return m_res;
  endfunction

  // Advance the model by one step event using the switches currently presented.
  task automatic model_step();
    exp_t e;
    int sv;
    sv = int'(i_sw);
    case (m_state)
      0: m_a = sv;
      1: m_b = sv;
      2: begin
        m_op = sv % 8;
        ref_alu(m_a, m_b, m_op, m_res, m_c, m_z, m_v);
        m_valid = 1;
        e.a = m_a; e.b = m_b; e.op = m_op;
        e.res = m_res; e.c = m_c; e.z = m_z; e.v = m_v;
        sb_q.push_back(e);
      end
      default: m_valid = 0;
    endcase
    m_state = (m_state + 1) % 4;
  endtask

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_valid = 0;
    m_res = 0; m_c = 0; m_z = 0; m_v = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(o_state), m_state);
    chk({tag, ".a_reg"}, int'(o_a_reg), m_a);
    chk({tag, ".b_reg"}, int'(o_b_reg), m_b);
    chk({tag, ".op_reg"}, int'(o_op_reg), m_op);
    chk({tag, ".valid"}, int'(o_result_valid), m_valid);
    chk({tag, ".result"}, int'(o_result), m_res);
    chk({tag, ".flags"}, int'({o_carry, o_zero, o_overflow}), (m_c << 2) | (m_z << 1) | m_v);
    chk({tag, ".display"}, int'(o_display), exp_display());
  endtask

  task automatic press(input int v, input string tag);
    i_sw = W'(v);
    i_rise = 1'b1;
    model_step();
    @(posedge clock);
    #1;
    i_rise = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      i_sw = W'($urandom);
      @(posedge clock);
      #1;
      check_all(tag);
    end
  endtask

  // Monitor: each rising edge of result_valid must match the oldest pending expectation.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (o_result_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("mon.unexpected_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          pops++;
          chk("mon.result", int'(o_result), e.res);
          chk("mon.carry", int'(o_carry), e.c);
          chk("mon.zero", int'(o_zero), e.z);
          chk("mon.overflow", int'(o_overflow), e.v);
          chk("mon.operands", int'({o_a_reg, o_b_reg, o_op_reg}),
              (e.a << (W + 3)) | (e.b << 3) | e.op);
          chk("mon.display", int'(o_display), e.res);
        end
      end
      prev_valid = o_result_valid;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int vals[4];
    repeat (3) @(posedge clock);
    #1;
    check_all("reset_init");
    rstsync = 1'b1;
    idle(2, "post_reset");

    // Directed vectors from the entry sequence.
    press(4'b0111, "add_a"); press(4'b1001, "add_b");
    press(3'b000, "add_op"); press(0, "add_wrap");
    press(4'b0101, "ovf_a"); press(4'b0100, "ovf_b");
    press(3'b000, "ovf_op"); press(0, "ovf_wrap");
    press(4'b0011, "sub_a"); press(4'b0101, "sub_b");
    press(3'b001, "sub_op"); press(0, "sub_wrap");
    press(4'b1010, "shl_a"); press(4'b0011, "shl_b");
    press(3'b110, "shl_op"); press(0, "shl_wrap");
    press(4'b1010, "shr_a"); press(4'b0011, "shr_b");
    press(3'b111, "shr_op"); press(0, "shr_wrap");

    // Four back-to-back step cycles with the switches changing every cycle.
    vals[0] = 2; vals[1] = 3; vals[2] = 0; vals[3] = int'($urandom_range(M - 1));
    i_rise = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_sw = W'(vals[i]);
      model_step();
      @(posedge clock);
      #1;
      check_all("burst");
    end
    i_rise = 1'b0;
    chk("burst.result_sum", int'(o_result), 5);
    idle(6, "sw_toggle_no_rise");

    // Reset mid-S_B with a simultaneous step pulse, then capture A after release.
    press(int'($urandom_range(M - 1)), "rst_pre_a");
    i_sw = W'($urandom);
    #2;
    rstsync = 1'b0;
    i_rise = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clock);
    #1;
    check_all("rst_rise_held");
    i_rise = 1'b0;
    rstsync = 1'b1;
    idle(1, "rst_release");
    press(3, "rst_then_a");
    chk("rst_then_a.a_is_3", int'(o_a_reg), 3);

    // Randomized sequences with random idle gaps between steps.
    for (int n = 0; n < 600; n++) begin
      idle(int'($urandom_range(2)), "rand_idle");
      press(int'($urandom_range(M - 1)), "rand_step");
    end

    idle(3, "drain");
    chk("sb.drained", sb_q.size(), 0);
    chk("sb.pops_seen", (pops > 100) ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_entry_fsm.md
# alu_entry_fsm

Operand-entry and execute controller for the lab ALU, sitting directly downstream of the button synchronizer. It consumes the synchronizer's one-cycle `rise` pulse as a "step" event and captures switch values in turn as operand A, operand B and opcode. It then evaluates the ALU and holds a registered result with flags for the display stage. Each button press advances exactly one step of the entry sequence.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 4 or more.
- `clock`  in  1  system clock.
- `rstsync`  in  1  reset, asynchronous, active-low.
- `rise`  in  1  step event; one-cycle pulse from the synchronizer, already synchronous to `clock`.
- `sw`  in  WIDTH  switch inputs; operand value, with opcode in `sw[2:0]`.
- `a_reg`  out  WIDTH  captured operand A.
- `b_reg`  out  WIDTH  captured operand B.
- `op_reg`  out  3  captured opcode.
- `result`  out  WIDTH  registered ALU result.
- `carry`, `zero`, `overflow`  out  1 each  registered flags.
- `result_valid`  out  1  high while `result` reflects the current operands and opcode.
- `state`  out  2  current step: 00 = S_A, 01 = S_B, 10 = S_OP, 11 = S_RES.
- `display`  out  WIDTH  value for the display stage.

## Operation
- **Reset** (`rstsync` = 0, at any time, including mid-sequence):
  - state goes to S_A.
  - `a_reg`, `b_reg`, `op_reg`, `result`, `carry`, `zero`, `overflow` and `result_valid` all go to 0.
- **State transitions.** Only a clock edge with `rise` = 1 changes state. Without `rise`, all registers hold.
  - S_A + rise: `a_reg` <= `sw`; go to S_B.
  - S_B + rise: `b_reg` <= `sw`; go to S_OP.
  - S_OP + rise: `op_reg` <= `sw[2:0]`. On the same edge, `result`, the flags and `result_valid` = 1 are registered, computed from `a_reg`, `b_reg` and `sw[2:0]`. Go to S_RES.
  - S_RES + rise: `result_valid` <= 0; go to S_A. `a_reg`, `b_reg`, `op_reg`, `result` and the flags hold their values until overwritten.
- **Opcodes.** All arithmetic is modulo 2^WIDTH.
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL: A<<1, zero fill.
  - 111 SHR: A>>1, logical, zero fill.
- **carry**:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 iff unsigned A < B.
  - SHL: the bit shifted out, A[WIDTH-1].
  - SHR: the bit shifted out, A[0].
  - All other opcodes: 0.
- **overflow**:
  - ADD: two's-complement signed overflow (operand signs equal and result sign differs).
  - SUB: signed overflow (operand signs differ and result sign differs from A's sign).
  - All other opcodes: 0.
- **zero**: 1 iff `result` == 0, for every opcode.
- **display** (combinational):
  - S_A or S_B: `sw`.
  - S_OP: `sw[2:0]` zero-extended to WIDTH.
  - S_RES: `result`.

## Timing
- Capture latency: a register loads on the clock edge where `rise` is sampled high and is visible the following cycle.
- Result latency: `result`, the flags and `result_valid` update on the same edge that captures `op_reg`, one cycle after the S_OP press is sampled. There is no further pipeline delay.
- `sw` is sampled only on edges with `rise` = 1; switch changes at any other time have no effect on registers.
- A `rise` held high for N consecutive cycles counts as N steps. Back-to-back pulses on consecutive cycles advance one state per cycle, with no dropped events.
- The state sequence wraps from S_RES to S_A. No other transitions exist, and the state encoding is exhaustive.
- Asynchronous reset takes effect immediately on assertion and overrides a simultaneous `rise`. Release is synchronous to `clock`, provided by the upstream reset synchronizer.

## Test plan
- Reset check: assert `rstsync` = 0 mid-S_B → `state` = 00, `result_valid` = 0, all data registers 0; the next `rise` with `sw` = 4'h3 loads `a_reg` = 3.
- WIDTH = 4, ADD: sequence A = 0111, B = 1001, op = 000 → `result` = 0000, `carry` = 1, `zero` = 1, `overflow` = 0, `result_valid` = 1, `display` = 0000.
- ADD signed overflow: A = 0101, B = 0100, op = 000 → `result` = 1001, `carry` = 0, `overflow` = 1, `zero` = 0.
- SUB with borrow: A = 0011, B = 0101, op = 001 → `result` = 1110, `carry` = 1, `overflow` = 0. A fourth `rise` → `state` = 00, `result_valid` = 0, `result` still 1110.
- SHL and SHR: A = 1010, op = 110 → `result` = 0100, `carry` = 1. Repeat the sequence with op = 111 → `result` = 0101, `carry` = 0.
- Back-to-back `rise` for 4 cycles with `sw` changing each cycle (2, 3, 000, x) → `a_reg` = 2, `b_reg` = 3, `result` = 5, then back in S_A. Toggling `sw` without `rise` leaves all registers unchanged.
